dcache_controller: RTL and testbench

//   Direct-mapped, write-back data cache between the cpu load/store port and data_memory.

---
 rtl/dcache_controller_if.sv | 30 +++
 rtl/dcache_controller.sv | 141 ++++++++++++++
 tb/tb_dcache_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// CPU load/store port and block-wide data-memory port of the data cache.
// The slave modport is the cache's view; master is the surrounding system.
interface dcache_controller_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: zero-stall hits, misses stall the cpu
// through an optional dirty write-back followed by a block fetch.
module dcache_controller #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input logic              CLK,
    input logic              RESET,
    dcache_controller_if.slave bus
);
    localparam int TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
    localparam int NBLK     = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_e;

    state_e state_q, state_d;

    logic [NBLK-1:0] valid_q, valid_d;
    logic [NBLK-1:0] dirty_q, dirty_d;
    logic [31:0]     fill_q, fill_d;

    logic [31:0]         data_q [NBLK];
    logic [TAG_BITS-1:0] tag_q  [NBLK];

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag;
    logic [OFFSET_BITS-1:0] off;
    logic                   req;
    logic                   hit;
    logic                   wr_byte;
    logic                   fill_en;

    logic        busy;
    logic        mem_rd;
    logic        mem_wr;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;

    assign idx = bus.ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign tag = bus.ADDRESS[7 -: TAG_BITS];
    assign off = bus.ADDRESS[OFFSET_BITS-1:0];
    assign req = bus.READ | bus.WRITE;
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            fill_q  <= fill_d;
        end
    end

    // Data and tag storage is deliberately left unreset; valid_q guards it.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= tag;
        end else if (wr_byte) begin
            data_q[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        fill_d  = fill_q;
        wr_byte = 1'b0;
        fill_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
                    else                              state_d = FETCH;
                end else if (bus.WRITE && hit) begin
                    wr_byte      = 1'b1;
                    dirty_d[idx] = 1'b1;
                end
            end
            WRITEBACK: begin
                if (!bus.MEM_BUSYWAIT) state_d = FETCH;
            end
            FETCH: begin
                if (!bus.MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                    fill_d  = bus.MEM_READDATA;
                end
            end
            UPDATE: begin
                state_d      = IDLE;
                fill_en      = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: busy = req && !hit;
            WRITEBACK: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[idx], idx};
                mem_wdata = data_q[idx];
            end
            FETCH: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = bus.ADDRESS[7:2];
            end
            UPDATE: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Stall is masked while reset is held so a pending request cannot raise it.
    assign bus.BUSYWAIT      = busy & RESET;
    assign bus.MEM_READ      = mem_rd;
    assign bus.MEM_WRITE     = mem_wr;
    assign bus.MEM_ADDRESS   = mem_addr;
    assign bus.MEM_WRITEDATA = mem_wdata;
    assign bus.READDATA      = hit ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: transaction-level cache/memory model plus
// a per-cycle compare process and literal checks from hand-worked vectors.
module tb_dcache_controller;
    localparam int LAT = 3;
    localparam int MC  = LAT + 1;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    dcache_controller_if bus();

    dcache_controller dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [5:0] a);
        case (a)
            6'h00:   mem_init = 32'hDDCCBBAA;
            6'h08:   mem_init = 32'h11223344;
            6'h11:   mem_init = 32'hA0B0C0D0;
            default: mem_init = {8'hC0 ^ {2'b00, a}, 8'h00, 8'h5A, {2'b00, a}};
        endcase
    endfunction

    // Data memory: fixed contents overlaid by written-back blocks.
    logic [31:0] wmem [64];
    logic [63:0] wvalid = '0;
    int          cnt;

    assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (cnt != LAT);
    assign bus.MEM_READDATA = wvalid[bus.MEM_ADDRESS] ? wmem[bus.MEM_ADDRESS]
                                                      : mem_init(bus.MEM_ADDRESS);

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) cnt <= 0;
        else if (bus.MEM_READ | bus.MEM_WRITE) cnt <= (cnt == LAT) ? 0 : cnt + 1;
        else cnt <= 0;
    end

    always @(posedge CLK) begin
        if (RESET && bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
            wmem[bus.MEM_ADDRESS]   <= bus.MEM_WRITEDATA;
            wvalid[bus.MEM_ADDRESS] <= 1'b1;
        end
    end

    // Reference model of cache contents and of memory as the cache sees it.
    logic [31:0] ref_mem  [64];
    logic [31:0] ref_data [8];
    logic [2:0]  ref_tag  [8];
    logic [7:0]  ref_valid;
    logic [7:0]  ref_dirty;

    logic [5:0]  exp_fetch, exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [7:0]  exp_rd;
    logic [7:0]  got_rd;

    int          n_rd = 0;
    int          n_wr = 0;
    logic [5:0]  last_fetch, last_wb_addr;
    logic [31:0] last_wb_data;

    always @(negedge CLK) begin
        if (RESET) begin
            check("mem_rw_exclusive", {31'b0, bus.MEM_READ & bus.MEM_WRITE}, 32'd0);
            if (bus.MEM_WRITE) begin
                n_wr++;
                last_wb_addr = bus.MEM_ADDRESS;
                last_wb_data = bus.MEM_WRITEDATA;
                check("wb_addr", {26'b0, bus.MEM_ADDRESS}, {26'b0, exp_wb_addr});
                check("wb_data", bus.MEM_WRITEDATA, exp_wb_data);
            end
            if (bus.MEM_READ) begin
                n_rd++;
                last_fetch = bus.MEM_ADDRESS;
                check("fetch_addr", {26'b0, bus.MEM_ADDRESS}, {26'b0, exp_fetch});
            end
            if (bus.READ && !bus.WRITE && !bus.BUSYWAIT)
                check("readdata", {24'b0, bus.READDATA}, {24'b0, exp_rd});
        end
    end

    task automatic req(input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
        logic [2:0] idx, tg;
        logic [1:0] off;
        logic       hit, wb;
        int         exp_busy, n, r0, w0;
        idx = a[4:2];
        tg  = a[7:5];
        off = a[1:0];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        wb  = !hit && ref_valid[idx] && ref_dirty[idx];
        exp_wb_addr = {ref_tag[idx], idx};
        exp_wb_data = ref_data[idx];
        exp_fetch   = a[7:2];
        exp_busy    = hit ? 0 : 2 + MC + (wb ? MC : 0);
        if (!hit) begin
            if (wb) ref_mem[{ref_tag[idx], idx}] = ref_data[idx];
            ref_data[idx]  = ref_mem[a[7:2]];
            ref_tag[idx]   = tg;
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_data[idx][off*8 +: 8] = d;
            ref_dirty[idx] = 1'b1;
        end
        exp_rd = ref_data[idx][off*8 +: 8];
        r0 = n_rd;
        w0 = n_wr;
        @(posedge CLK);
        #1;
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = a;
        bus.WRITEDATA = d;
        n = 0;
        @(negedge CLK);
        while (bus.BUSYWAIT && n < 60) begin
            n++;
            @(negedge CLK);
        end
        got_rd = bus.READDATA;
        check("busy_cycles", n, exp_busy);
        check("did_fetch", {31'b0, n_rd != r0}, {31'b0, !hit});
        check("did_writeback", {31'b0, n_wr != w0}, {31'b0, wb});
        @(posedge CLK);
        #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        int n, r0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_init(6'(i));
        ref_valid     = '0;
        ref_dirty     = '0;
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = 8'h00;
        bus.WRITEDATA = 8'h00;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
        check("rst_mem_write", {31'b0, bus.MEM_WRITE}, 32'd0);
        check("rst_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'd0);
        check("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
        check("rst_readdata", {24'b0, bus.READDATA}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        req(1'b1, 1'b0, 8'h00, 8'h00);
        check("t1_read_miss", {24'b0, got_rd}, 32'hAA);
        check("t1_fetch_addr", {26'b0, last_fetch}, 32'h00);

        req(1'b1, 1'b0, 8'h03, 8'h00);
        check("t2_read_hit", {24'b0, got_rd}, 32'hDD);

        req(1'b0, 1'b1, 8'h01, 8'h55);
        req(1'b1, 1'b0, 8'h01, 8'h00);
        check("t3_write_hit", {24'b0, got_rd}, 32'h55);

        req(1'b1, 1'b0, 8'h20, 8'h00);
        check("t4_wb_addr", {26'b0, last_wb_addr}, 32'h00);
        check("t4_wb_data", last_wb_data, 32'hDDCC55AA);
        check("t4_fetch_addr", {26'b0, last_fetch}, 32'h08);
        check("t4_readdata", {24'b0, got_rd}, 32'h44);

        req(1'b1, 1'b0, 8'h01, 8'h00);
        check("t4_refetch_merged", {24'b0, got_rd}, 32'h55);

        req(1'b0, 1'b1, 8'h44, 8'h7E);
        req(1'b1, 1'b0, 8'h44, 8'h00);
        check("t5_write_miss", {24'b0, got_rd}, 32'h7E);
        req(1'b1, 1'b0, 8'h64, 8'h00);
        check("t5_wb_addr", {26'b0, last_wb_addr}, 32'h11);
        check("t5_wb_data", last_wb_data, 32'hA0B0C07E);
        check("t5_readdata", {24'b0, got_rd}, 32'h19);

        // Request abandoned mid-miss: the fill must still land.
        exp_fetch = 6'h22;
        r0 = n_rd;
        @(posedge CLK);
        #1;
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h88;
        repeat (2) @(posedge CLK);
        #1;
        bus.READ = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        check("drop_fetched", {31'b0, n_rd != r0}, 32'd1);
        check("drop_idle_busy", {31'b0, bus.BUSYWAIT}, 32'd0);
        ref_data[2]  = ref_mem[6'h22];
        ref_tag[2]   = 3'd4;
        ref_valid[2] = 1'b1;
        ref_dirty[2] = 1'b0;
        req(1'b1, 1'b0, 8'h8B, 8'h00);
        check("drop_then_hit", {24'b0, got_rd}, 32'hE2);

        // Reset while the fetch is outstanding.
        exp_fetch = 6'h1B;
        @(posedge CLK);
        #1;
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h6C;
        n = 0;
        @(negedge CLK);
        while (!bus.MEM_READ && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check("t6_in_fetch", {31'b0, bus.MEM_READ}, 32'd1);
        #1;
        RESET = 1'b0;
        #1;
        check("t6_mem_read_drop", {31'b0, bus.MEM_READ}, 32'd0);
        check("t6_busywait_drop", {31'b0, bus.BUSYWAIT}, 32'd0);
        check("t6_mem_write_low", {31'b0, bus.MEM_WRITE}, 32'd0);
        bus.READ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET     = 1'b1;
        ref_valid = '0;
        ref_dirty = '0;
        req(1'b1, 1'b0, 8'h6C, 8'h00);
        check("t6_refetch", {24'b0, got_rd}, 32'h1B);

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
